// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier with start/busy/done handshake,
// built around a gate-level ripple-carry adder.

module fullAdder (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = x ^ y ^ ci;
   assign co = (x & y) | (ci & (x ^ y));
endmodule

module rippleCarryAdder #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             ci,
   output logic [WIDTH-1:0] sum,
   output logic             co
);
   logic [WIDTH:0] carry;

   assign carry[0] = ci;

   for (genvar i = 0; i < WIDTH; i++) begin : gStage
      fullAdder uFa (
         .x (x[i]),
         .y (y[i]),
         .ci(carry[i]),
         .s (sum[i]),
         .co(carry[i+1])
      );
   end

   assign co = carry[WIDTH];
endmodule

module shift_add_multiplier #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } stateT;

   stateT              state;
   logic [WIDTH-1:0]   m;
   logic [2*WIDTH-1:0] p;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   sum;
   logic               carryOut;
   logic               accept;

   rippleCarryAdder #(.WIDTH(WIDTH)) uAdder (
      .x  (p[2*WIDTH-1:WIDTH]),
      .y  (m),
      .ci (1'b0),
      .sum(sum),
      .co (carryOut)
   );

   // A start in DONE is taken exactly like one in IDLE (back-to-back).
   assign accept  = start && (state != RUN);
   assign product = p;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         p     <= '0;
         m     <= '0;
         cnt   <= '0;
      end else if (accept) begin
         m     <= a;
         p     <= {{WIDTH{1'b0}}, b};
         cnt   <= CW'(WIDTH);
         state <= RUN;
         busy  <= 1'b1;
         done  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               busy <= 1'b0;
               done <= 1'b0;
            end
            RUN: begin
               if (p[0]) begin
                  p <= {carryOut, sum, p[WIDTH-1:1]};
               end else begin
                  p <= {1'b0, p[2*WIDTH-1:1]};
               end
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier (WIDTH=4): directed vectors,
// expected products and done cycles queued at issue, checked by a monitor.

module tb_shift_add_multiplier;
   localparam int W = 4;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           start = 1'b0;
   logic [W-1:0]   a = '0;
   logic [W-1:0]   b = '0;
   logic           busy;
   logic           done;
   logic [2*W-1:0] product;

   int cyc = 0;
   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [2*W-1:0] prod;
      int             cyc;
   } expT;

   expT sb[$];

   shift_add_multiplier #(.WIDTH(W)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .product(product)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!reset && done) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: product=%0d at cycle %0d, none expected",
                     product, cyc);
         end else begin
            expT e;
            e = sb.pop_front();
            if (product !== e.prod || cyc != e.cyc) begin
               errors++;
               $display("FAIL done_product: got %0d at cycle %0d, want %0d at cycle %0d",
                        product, cyc, e.prod, e.cyc);
            end
         end
      end
   end

   task automatic check(input string name, input logic [15:0] got,
                        input logic [15:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   // Drive start for one edge; returns #1 after the accepting edge E0.
   task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [2*W-1:0] expProd);
      @(posedge clk); #1;
      start = 1'b1;
      a = av;
      b = bv;
      sb.push_back('{expProd, cyc + 5});
      @(posedge clk); #1;
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
   endtask

   // Bounded wait; returns #1 after the edge that raises done.
   task automatic waitDone(input string name);
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk); #1;
         if (done) seen = 1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s_timeout: done=0 want 1", name);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge clk); #1;
      check("reset_busy", 16'(busy), 16'd0);
      check("reset_done", 16'(done), 16'd0);
      check("reset_product", 16'(product), 16'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // 3*5 with busy/done timing
      issue(4'd3, 4'd5, 8'd15);
      check("busy_e0", 16'(busy), 16'd1);
      for (int i = 1; i < 4; i++) begin
         @(posedge clk); #1;
         check("busy_run", 16'(busy), 16'd1);
         check("done_early", 16'(done), 16'd0);
      end
      @(posedge clk); #1;
      check("busy_at_done", 16'(busy), 16'd0);
      check("done_pulse", 16'(done), 16'd1);
      check("product_3x5", 16'(product), 16'd15);
      @(posedge clk); #1;
      check("done_cleared", 16'(done), 16'd0);
      @(posedge clk); #1;
      check("product_hold", 16'(product), 16'd15);

      issue(4'd15, 4'd15, 8'd225);
      waitDone("15x15");
      issue(4'd0, 4'd13, 8'd0);
      waitDone("0x13");
      issue(4'd13, 4'd0, 8'd0);
      waitDone("13x0");

      // start during RUN is ignored
      issue(4'd7, 4'd9, 8'd63);
      start = 1'b1;
      a = 4'd1;
      b = 4'd1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_ignored_start", 16'(busy), 16'd1);
      waitDone("7x9");

      // back-to-back: second start held in the DONE cycle
      issue(4'd6, 4'd7, 8'd42);
      waitDone("6x7");
      start = 1'b1;
      a = 4'd9;
      b = 4'd10;
      sb.push_back('{8'd90, cyc + 5});
      @(posedge clk); #1;
      start = 1'b0;
      check("b2b_busy", 16'(busy), 16'd1);
      check("b2b_done_low", 16'(done), 16'd0);
      waitDone("9x10");

      // reset mid-operation discards the result
      issue(4'd11, 4'd12, 8'd132);
      @(posedge clk); #1;
      reset = 1'b1;
      void'(sb.pop_back());
      @(posedge clk); #1;
      reset = 1'b0;
      check("midreset_busy", 16'(busy), 16'd0);
      check("midreset_done", 16'(done), 16'd0);
      check("midreset_product", 16'(product), 16'd0);
      repeat (8) @(posedge clk);
      #1;
      issue(4'd11, 4'd12, 8'd132);
      waitDone("11x12");
      repeat (3) @(posedge clk);
      #1;

      check("scoreboard_empty", 16'(sb.size()), 16'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
